dma_read_engine: RTL and testbench

Upstream neighbour of control_register in the matrix accelerator. It takes a burst command (dma_start, base address, burst length) and issues one read request to the 32-bit memory port. It packs the returned 32-bit words into 256-bit beats and delivers them on the dma_valid/dma_ready/dma_data handshake that control_register consumes.

---
 rtl/accel_pkg.sv | 9 +
 rtl/word_packer.sv | 54 +++++
 rtl/dma_read_engine.sv | 102 ++++++++++
 tb/tb_dma_read_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the matrix accelerator DMA front end.
package accel_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} dma_state_e;

  localparam int DMA_DATA_W     = 256;
  localparam int DMA_MEM_W      = 32;
  localparam int WORDS_PER_BEAT = DMA_DATA_W / DMA_MEM_W;
  localparam int REQ_LEN_W      = 8;
endpackage

// File: rtl/word_packer.sv
// Packs MEM_WIDTH response words into DATA_WIDTH beats behind a valid/ready output register.
module word_packer
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_W,
  parameter int MEM_WIDTH  = DMA_MEM_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [MEM_WIDTH-1:0]  rsp_data,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [DATA_WIDTH-1:0] beat_data,
  output logic                  beat_fire
);
  localparam int WPB = DATA_WIDTH / MEM_WIDTH;
  localparam int WW  = $clog2(WPB);

  logic [WPB-1:0][MEM_WIDTH-1:0] lanes;
  logic [WW-1:0]                 w;
  logic                          last_word, word_fire;

  assign last_word = (w == WW'(WPB - 1));
  // Only the closing word has to wait for the output register to drain.
  assign rsp_ready = en && !(last_word && beat_valid && !beat_ready);
  assign word_fire = rsp_valid && rsp_ready;
  assign beat_fire = beat_valid && beat_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lanes <= '0;
      w     <= '0;
    end else if (word_fire) begin
      lanes[w] <= rsp_data;
      w        <= last_word ? '0 : w + 1'b1;
    end
  end

  // The last word goes straight into the beat, so a full beat costs no extra cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_valid <= 1'b0;
      beat_data  <= '0;
    end else if (word_fire && last_word) begin
      beat_valid <= 1'b1;
      beat_data  <= {rsp_data, lanes[WPB-2:0]};
    end else if (beat_fire) begin
      beat_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/dma_read_engine.sv
// Burst read engine: one memory request per command, response words repacked into wide beats.
module dma_read_engine
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_W,
  parameter int MEM_WIDTH  = DMA_MEM_W,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dma_start,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [LEN_WIDTH-1:0]  dma_burst_len,
  output logic                  dma_valid,
  input  logic                  dma_ready,
  output logic [DATA_WIDTH-1:0] dma_data,
  output logic                  dma_busy,
  output logic                  dma_done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [REQ_LEN_W-1:0]  mem_req_len,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [MEM_WIDTH-1:0]  mem_rsp_data
);
  localparam int WB = $clog2(DATA_WIDTH / MEM_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  dma_state_e               state, state_nxt;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [LEN_WIDTH-1:0]     len_q, beat_cnt;
  logic [REQ_LEN_W-1:0]     req_len;
  logic                     beat_fire, pack_en;

  assign req_len = REQ_LEN_W'({len_q, {WB{1'b1}}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && dma_start) begin
        addr_q   <= dma_addr & ~ALIGN_MASK;
        len_q    <= dma_burst_len;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_len   = '0;
    dma_busy      = 1'b0;
    dma_done      = 1'b0;
    pack_en       = 1'b0;
    case (state)
      IDLE: if (dma_start) state_nxt = REQ;
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_len   = req_len;
        dma_busy      = 1'b1;
        if (mem_req_ready) state_nxt = DATA;
      end
      DATA: begin
        dma_busy = 1'b1;
        pack_en  = 1'b1;
        if (beat_fire && beat_cnt == len_q) state_nxt = DONE;
      end
      DONE: begin
        dma_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WIDTH  (MEM_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .en         (pack_en),
    .rsp_valid  (mem_rsp_valid),
    .rsp_ready  (mem_rsp_ready),
    .rsp_data   (mem_rsp_data),
    .beat_valid (dma_valid),
    .beat_ready (dma_ready),
    .beat_data  (dma_data),
    .beat_fire  (beat_fire)
  );
endmodule

// File: tb/tb_dma_read_engine.sv
// Scoreboard bench for dma_read_engine: memory/consumer models plus a negedge monitor.
module tb_dma_read_engine;
  localparam int DW = 256, MW = 32, AW = 32, LW = 4;

  logic          clk = 1'b0, rstn = 1'b1;
  logic          dma_start = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [LW-1:0] dma_burst_len = '0;
  logic          dma_valid, dma_ready = 1'b0;
  logic [DW-1:0] dma_data;
  logic          dma_busy, dma_done;
  logic          mem_req_valid, mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [7:0]    mem_req_len;
  logic          mem_rsp_valid = 1'b0, mem_rsp_ready;
  logic [MW-1:0] mem_rsp_data = '0;

  always #5 clk = ~clk;

  dma_read_engine dut (
    .clk(clk), .rstn(rstn), .dma_start(dma_start), .dma_addr(dma_addr),
    .dma_burst_len(dma_burst_len), .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_data(dma_data), .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [7:0] len;} req_t;

  int checks = 0, errors = 0;
  req_t          exp_req[$];
  logic [DW-1:0] exp_beats[$];
  logic [MW-1:0] words[$];

  // Transaction-level model of one command in flight
  bit  active, data_phase, done_due, was_active, rr_exp;
  int  wcnt, words_acc, beats_seen, exp_nbeats, done_cnt;
  int  ready_mode, req_stall, data_mode;
  bit  mem_full;
  logic [31:0]   next_word, wd;
  logic [DW-1:0] bt, last_beat;
  logic [AW-1:0] last_req_addr;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_checks();
    check("rst dma_valid", dma_valid, 0);
    check("rst dma_data", dma_data, 0);
    check("rst dma_busy", dma_busy, 0);
    check("rst dma_done", dma_done, 0);
    check("rst mem_req_valid", mem_req_valid, 0);
    check("rst mem_req_addr", mem_req_addr, 0);
    check("rst mem_req_len", mem_req_len, 0);
    check("rst mem_rsp_ready", mem_rsp_ready, 0);
  endtask

  // Scoreboard monitor: evaluates the handshakes that the next rising edge will commit
  always @(negedge clk) begin
    if (rstn) begin
      was_active = active;
      check("dma_busy", dma_busy, active && !done_due);
      check("dma_done", dma_done, done_due);
      if (done_due) begin
        check("beat_count", beats_seen, exp_nbeats);
        active = 0; done_due = 0; done_cnt++;
      end
      rr_exp = data_phase && !(wcnt == 7 && dma_valid && !dma_ready);
      check("mem_rsp_ready", mem_rsp_ready, rr_exp);
      if (mem_req_valid) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req: unexpected request addr %h len %0d", mem_req_addr, mem_req_len);
        end else begin
          check("mem_req_addr", mem_req_addr, exp_req[0].addr);
          check("mem_req_len", mem_req_len, exp_req[0].len);
          if (mem_req_ready) begin
            void'(exp_req.pop_front());
            last_req_addr = mem_req_addr;
            data_phase = 1; wcnt = 0;
            for (int b = 0; b < exp_nbeats; b++) begin
              bt = '0;
              for (int k = 0; k < 8; k++) begin
                wd = (data_mode != 0) ? next_word : $urandom;
                if (data_mode != 0) next_word++;
                words.push_back(wd);
                bt[32*k +: 32] = wd;
              end
              exp_beats.push_back(bt);
            end
          end
        end
      end
      if (mem_rsp_valid && mem_rsp_ready) begin
        wcnt = (wcnt + 1) % 8;
        words_acc++;
      end
      if (dma_valid) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL dma_valid: beat %h with nothing expected", dma_data);
        end else begin
          check("dma_data", dma_data, exp_beats[0]);
          if (dma_ready) begin
            last_beat = dma_data;
            void'(exp_beats.pop_front());
            beats_seen++;
            if (beats_seen == exp_nbeats) begin data_phase = 0; done_due = 1; end
          end
        end
      end
      if (dma_start && !was_active) begin
        exp_nbeats = int'(dma_burst_len) + 1;
        exp_req.push_back('{addr: dma_addr & ~32'h1f, len: 8'(exp_nbeats * 8 - 1)});
        active = 1; beats_seen = 0; words_acc = 0;
      end
    end
  end

  // Memory responder: words stay presented until accepted
  initial begin : mem_drv
    bit fire;
    forever begin
      @(negedge clk);
      fire = mem_rsp_valid && mem_rsp_ready && rstn;
      @(posedge clk); #1;
      if (!rstn) begin
        mem_rsp_valid = 1'b0;
      end else begin
        if (fire && words.size() > 0) void'(words.pop_front());
        if (!(mem_rsp_valid && !fire)) begin
          if (words.size() > 0 && (mem_full || $urandom_range(0, 3) != 0)) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = words[0];
          end else begin
            mem_rsp_valid = 1'b0;
          end
        end
      end
    end
  end

  // Consumer and request-port ready drivers
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: dma_ready = 1'b1;
      1: dma_ready = ~dma_ready;
      2: dma_ready = 1'($urandom_range(0, 1));
      default: dma_ready = 1'b0;
    endcase
    mem_req_ready = (req_stall == 0);
    if (mem_req_valid && req_stall > 0) req_stall--;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(posedge clk); #1;
    dma_start = 1'b1; dma_addr = a; dma_burst_len = l;
    @(posedge clk); #1;
    dma_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rstn = 1'b0; #1;
    reset_checks();
    words.delete(); exp_req.delete(); exp_beats.delete();
    active = 0; data_phase = 0; done_due = 0; wcnt = 0;
    dma_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (active && n < budget) begin tick(1); n++; end
    checks++;
    if (active) begin
      errors++;
      $display("FAIL timeout: command still active after %0d cycles", budget);
      do_reset();
    end
  endtask

  initial begin
    int d0, n;
    ready_mode = 0; req_stall = 0; data_mode = 1; mem_full = 1; next_word = 1;
    #2 rstn = 1'b0; #1;
    reset_checks();
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;

    // Single beat, incrementing data 1..8
    issue(32'h0000_0040, 4'd0);
    wait_idle(100);
    check("t1 req_addr", last_req_addr, 32'h40);
    check("t1 lane0", last_beat[31:0], 1);
    check("t1 lane7", last_beat[255:224], 8);

    // Misaligned base address
    data_mode = 0;
    issue(32'h0000_0013, 4'd0);
    wait_idle(100);
    check("t2 req_addr", last_req_addr, 0);

    // Backpressure: consumer stalled while 16 words stream in
    ready_mode = 3;
    issue(32'h0000_1000, 4'd1);
    tick(22);
    check("t3 words_held", words_acc, 15);
    check("t3 beat_pending", dma_valid, 1);
    ready_mode = 0;
    wait_idle(100);
    check("t3 beats", beats_seen, 2);

    // Full burst with ready toggling every cycle
    ready_mode = 1; data_mode = 1;
    issue(32'h0000_2000, 4'd15);
    wait_idle(400);
    check("t4 beats", beats_seen, 16);

    // Request stall plus a start while busy
    ready_mode = 2; data_mode = 0; req_stall = 5; mem_full = 0;
    d0 = done_cnt;
    issue(32'h0000_3000, 4'd2);
    tick(10);
    issue(32'h0000_4444, 4'd5);
    wait_idle(300);
    tick(20);
    check("t5 done_count", done_cnt - d0, 1);
    check("t5 req_addr", last_req_addr, 32'h3000);

    // Reset mid-burst, then a clean burst
    ready_mode = 0; mem_full = 1;
    issue(32'h0000_5000, 4'd3);
    n = 0;
    while (beats_seen < 2 && n < 200) begin tick(1); n++; end
    check("t6 reached_beat2", beats_seen, 2);
    do_reset();
    issue(32'h0000_6000, 4'd1);
    wait_idle(200);
    check("t6 beats", beats_seen, 2);
    check("t6 req_addr", last_req_addr, 32'h6000);

    // Randomized commands
    repeat (6) begin
      ready_mode = $urandom_range(0, 2);
      mem_full   = 1'($urandom_range(0, 1));
      req_stall  = $urandom_range(0, 3);
      issue($urandom, 4'($urandom_range(0, 15)));
      wait_idle(800);
    end
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
